// File: rtl/char_stream_checker.sv
// Purpose : measures a DATA_WIDTH/CTRL_WIDTH character bus over a fixed window, classifying,
//           pattern-checking and counting every octet, then grading the data-character ratio.
// Latency : window results and o_done appear WINDOW_CYCLES edges after the start edge; no backpressure (bus sampled every beat).
// Ports   : clk, rst (sync, active-high); i_data/i_ctrl character bus; i_start opens a window (IDLE only);
//           o_busy (MEASURE), o_done (1-cycle pulse), o_data_cnt/o_ctrl_cnt/o_err_cnt, o_first_err_beat, o_pass.
module char_stream_checker #(
   parameter int         DATA_WIDTH    = 64,
   parameter int         CTRL_WIDTH    = DATA_WIDTH/8,
   parameter logic [7:0] DATA_PATTERN  = 8'hAA,
   parameter logic [7:0] CTRL_PATTERN  = 8'h55,
   parameter int         WINDOW_CYCLES = 1024,
   parameter int         CNT_WIDTH     = 32,
   parameter int         EXP_PROB      = 70,
   parameter int         TOL_PROB      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [CTRL_WIDTH-1:0] i_ctrl,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [CNT_WIDTH-1:0]  o_data_cnt,
   output logic [CNT_WIDTH-1:0]  o_ctrl_cnt,
   output logic [CNT_WIDTH-1:0]  o_err_cnt,
   output logic [CNT_WIDTH-1:0]  o_first_err_beat,
   output logic                  o_pass
);

   localparam int BW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;  // beat index width
   localparam int IW = $clog2(CTRL_WIDTH + 1);                           // per-beat octet count width
   localparam int PW = CNT_WIDTH + 7;                                    // holds count*100 without overflow
   localparam int LO = (EXP_PROB > TOL_PROB) ? (EXP_PROB - TOL_PROB) : 0;
   localparam int HI = ((EXP_PROB + TOL_PROB) > 100) ? 100 : (EXP_PROB + TOL_PROB);
   localparam logic [PW-1:0] LO_TOT =
      PW'(longint'(LO) * longint'(WINDOW_CYCLES) * longint'(CTRL_WIDTH));
   localparam logic [PW-1:0] HI_TOT =
      PW'(longint'(HI) * longint'(WINDOW_CYCLES) * longint'(CTRL_WIDTH));

   typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        beat_q;
   logic [CNT_WIDTH-1:0] data_q, ctrl_q, err_q, ferr_q;
   logic [CNT_WIDTH-1:0] data_n, ctrl_n, err_n, ferr_n;
   logic [IW-1:0]        beat_ctrl, beat_data, beat_err;
   logic [PW-1:0]        data_x100;
   logic                 last_beat, pass_n;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [IW-1:0]        b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {{(CNT_WIDTH+1-IW){1'b0}}, b};
      sat_add = s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   // Per-beat classification: a mismatching octet is still counted as data/ctrl by its ctrl bit.
   always_comb begin
      beat_ctrl = '0;
      beat_err  = '0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         beat_ctrl = beat_ctrl + IW'(i_ctrl[i]);
         if (i_data[i*8 +: 8] != (i_ctrl[i] ? CTRL_PATTERN : DATA_PATTERN))
            beat_err = beat_err + IW'(1);
      end
      beat_data = IW'(CTRL_WIDTH) - beat_ctrl;
   end

   assign last_beat = (beat_q == BW'(WINDOW_CYCLES - 1));
   assign data_n    = sat_add(data_q, beat_data);
   assign ctrl_n    = sat_add(ctrl_q, beat_ctrl);
   assign err_n     = sat_add(err_q, beat_err);
   // err_q still zero means no earlier beat has failed, so this is the first bad beat.
   assign ferr_n    = ((err_q == '0) && (beat_err != '0)) ? CNT_WIDTH'(beat_q) : ferr_q;
   assign data_x100 = {7'b0, data_n} * PW'(100);
   // A saturated error count is non-zero, so it also fails here.
   assign pass_n    = (err_n == '0) && (data_x100 >= LO_TOT) && (data_x100 <= HI_TOT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start)   state_d = MEASURE;
         MEASURE: if (last_beat) state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         beat_q           <= '0;
         data_q           <= '0;
         ctrl_q           <= '0;
         err_q            <= '0;
         ferr_q           <= '1;
         o_data_cnt       <= '0;
         o_ctrl_cnt       <= '0;
         o_err_cnt        <= '0;
         o_first_err_beat <= '1;
         o_pass           <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  beat_q <= '0;
                  data_q <= '0;
                  ctrl_q <= '0;
                  err_q  <= '0;
                  ferr_q <= '1;
               end
            end
            MEASURE: begin
               beat_q <= beat_q + BW'(1);
               data_q <= data_n;
               ctrl_q <= ctrl_n;
               err_q  <= err_n;
               ferr_q <= ferr_n;
               // Results include the beat sampled on this final edge.
               if (last_beat) begin
                  o_data_cnt       <= data_n;
                  o_ctrl_cnt       <= ctrl_n;
                  o_err_cnt        <= err_n;
                  o_first_err_beat <= ferr_n;
                  o_pass           <= pass_n;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy = (state_q == MEASURE);
   assign o_done = (state_q == DONE);

endmodule
